// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: segment codes,
// controller state encoding and BCD width helper.
package seven_seg_pkg;

    // Active-low {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } scan_state_t;

    function automatic int bcd_w(input int num_digits);
        return 4 * num_digits;
    endfunction

    function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock,
// DATA_W steps per conversion, done is high during the final step.
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int DATA_W     = 13,
    parameter int NUM_DIGITS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [DATA_W-1:0]                din,
    output logic                             done,
    output logic [bcd_w(NUM_DIGITS)-1:0]     bcd
);

    localparam int BCD_W = bcd_w(NUM_DIGITS);
    localparam int CNT_W = $clog2(DATA_W);

    logic                running;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   bin_sr;
    logic [BCD_W-1:0]    bcd_sr;
    logic [BCD_W-1:0]    bcd_adj;

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    assign done = running && (cnt == CNT_W'(DATA_W - 1));
    assign bcd  = bcd_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            cnt <= cnt + CNT_W'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

    // Shift registers carry data only; the control block above qualifies them.
    always_ff @(posedge clk) begin
        if (start) begin
            bin_sr <= din;
            bcd_sr <= '0;
        end else if (running) begin
            {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// N-digit multiplexed seven-segment driver with handshake input, sequential
// BCD conversion, atomic digit commit and anode scanning. Optional macro: SSEG_SIGNED_EN.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 13,
    parameter int REFRESH_DIV = 262144,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg
);

    localparam int BCD_W = bcd_w(NUM_DIGITS);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [63:0] MAX_ALL = 64'(10 ** NUM_DIGITS) - 64'd1;

    scan_state_t         state;
    scan_state_t         state_next;
    logic                armed;
    logic                accept;
    logic                conv_done;
    logic [BCD_W-1:0]    conv_bcd;

    logic [DATA_W-1:0]   in_mag;
    logic                in_ovf;
    logic                cap_ovf;

    logic [BCD_W-1:0]    disp_bcd;
    logic                disp_ovf;

    logic [PRE_W-1:0]    pre;
    logic [IDX_W-1:0]    idx;

    logic [3:0]          digits [NUM_DIGITS];
    logic [3:0]          cur;
    logic [IDX_W-1:0]    hi;
    logic [NUM_DIGITS-1:0] anode_next;
    logic [6:0]          seg_next;

`ifdef SSEG_SIGNED_EN
    localparam logic [63:0] MAX_NEG = 64'(10 ** (NUM_DIGITS - 1)) - 64'd1;

    logic                in_neg;
    logic                cap_neg;
    logic                disp_neg;
    logic                sign_here;

    // Magnitude kept DATA_W bits unsigned so the most negative value maps correctly.
    assign in_neg = in_data[DATA_W-1];
    assign in_mag = in_neg ? (~in_data + DATA_W'(1)) : in_data;
    assign in_ovf = in_neg ? (64'(in_mag) > MAX_NEG) : (64'(in_mag) > MAX_ALL);
`else
    assign in_mag = in_data;
    assign in_ovf = 64'(in_data) > MAX_ALL;
`endif

    assign in_ready = armed && (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .din   (in_mag),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = CONV;
            CONV:    if (conv_done) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Flags are sampled alongside the value and held until the commit edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_ovf <= in_ovf;
`ifdef SSEG_SIGNED_EN
            cap_neg <= in_neg;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
`ifdef SSEG_SIGNED_EN
            disp_neg <= 1'b0;
`endif
        end else if (state == COMMIT) begin
            disp_bcd <= conv_bcd;
            disp_ovf <= cap_ovf;
`ifdef SSEG_SIGNED_EN
            disp_neg <= cap_neg;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_W'(REFRESH_DIV - 1)) begin
            pre <= '0;
            if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    always_comb begin
        hi = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits[i] = disp_bcd[4*i +: 4];
        end
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_bcd[4*i +: 4] != 4'd0) begin
                hi = IDX_W'(i);
            end
        end
        cur = digits[idx];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            anode_next[i] = (idx != IDX_W'(i));
        end
    end

`ifdef SSEG_SIGNED_EN
    assign sign_here = (BLANK_LZ != 0)
                     ? ({1'b0, idx} == ({1'b0, hi} + (IDX_W + 1)'(1)))
                     : (idx == IDX_W'(NUM_DIGITS - 1));
`endif

    // Priority: overflow dashes, then sign dash, then leading-zero blanking.
    always_comb begin
        seg_next = seg_of_digit(cur);
        if ((BLANK_LZ != 0) && (idx > hi)) begin
            seg_next = SEG_BLANK;
        end
`ifdef SSEG_SIGNED_EN
        if (disp_neg && sign_here) begin
            seg_next = SEG_DASH;
        end
`endif
        if (disp_ovf) begin
            seg_next = SEG_DASH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode <= '1;
            seg   <= SEG_BLANK;
        end else begin
            anode <= anode_next;
            seg   <= seg_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: one 13-bit blanking instance and one
// 14-bit non-blanking instance, both scanning with REFRESH_DIV=4.
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_a, in_valid_b;
    logic [12:0] in_data_a;
    logic [13:0] in_data_b;
    logic        in_ready_a, in_ready_b;
    logic        busy_a, busy_b;
    logic [3:0]  anode_a, anode_b;
    logic [6:0]  seg_a, seg_b;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] CODE [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                         7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                         7'b0000000, 7'b0000100};
    localparam logic [6:0] DASH  = 7'b1111110;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic [6:0] disp [4];

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .NUM_DIGITS (4), .DATA_W (13), .REFRESH_DIV (4), .BLANK_LZ (1)
    ) dut (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid_a), .in_ready (in_ready_a),
        .in_data (in_data_a), .busy (busy_a), .anode (anode_a), .seg (seg_a)
    );

    seven_seg_scan_driver #(
        .NUM_DIGITS (4), .DATA_W (14), .REFRESH_DIV (4), .BLANK_LZ (0)
    ) dut_nb (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid_b), .in_ready (in_ready_b),
        .in_data (in_data_b), .busy (busy_b), .anode (anode_b), .seg (seg_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int which);
        return (which == 0) ? in_ready_a : in_ready_b;
    endfunction

    task automatic load(input int which, input logic [13:0] v);
        int n;
        n = 0;
        @(negedge clk);
        if (which == 0) begin
            in_valid_a = 1'b1;
            in_data_a  = v[12:0];
        end else begin
            in_valid_b = 1'b1;
            in_data_b  = v;
        end
        while (!rdy(which) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("load_wait_timeout", 32'(n >= 100), 32'd0);
        @(negedge clk);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic wait_ready(input int which, output int n);
        n = 0;
        while (!rdy(which) && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("ready_timeout", 32'(n >= 200), 32'd0);
    endtask

    task automatic read_disp(input int which);
        logic [3:0] an;
        logic [6:0] sg;
        for (int i = 0; i < 4; i++) disp[i] = 7'h55;
        repeat (2) @(negedge clk);
        repeat (20) begin
            an = (which == 0) ? anode_a : anode_b;
            sg = (which == 0) ? seg_a : seg_b;
            for (int i = 0; i < 4; i++) begin
                if (an == 4'(~(4'b0001 << i))) disp[i] = sg;
            end
            @(negedge clk);
        end
    endtask

    task automatic show(input string tag, input int which, input logic [13:0] v,
                        input logic [6:0] e3, input logic [6:0] e2,
                        input logic [6:0] e1, input logic [6:0] e0);
        int n;
        load(which, v);
        wait_ready(which, n);
        read_disp(which);
        chk({tag, "_d3"}, 32'(disp[3]), 32'(e3));
        chk({tag, "_d2"}, 32'(disp[2]), 32'(e2));
        chk({tag, "_d1"}, 32'(disp[1]), 32'(e1));
        chk({tag, "_d0"}, 32'(disp[0]), 32'(e0));
    endtask

    initial begin
        int n;
        int run;
        int bad_onehot;
        logic [3:0] a;

        rst_n      = 1'b0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_data_a  = '0;
        in_data_b  = '0;

        repeat (3) @(negedge clk);
        chk("rst_anode", 32'(anode_a), 32'h0F);
        chk("rst_seg", 32'(seg_a), 32'h7F);
        chk("rst_ready", 32'(in_ready_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready_a), 32'd1);
        chk("post_rst_anode", 32'(anode_a), 32'hE);
        chk("post_rst_seg", 32'(seg_a), 32'(CODE[0]));

        read_disp(0);
        chk("zero_d3", 32'(disp[3]), 32'(BLANK));
        chk("zero_d2", 32'(disp[2]), 32'(BLANK));
        chk("zero_d1", 32'(disp[1]), 32'(BLANK));
        chk("zero_d0", 32'(disp[0]), 32'(CODE[0]));
        read_disp(1);
        chk("zero_nb_d3", 32'(disp[3]), 32'(CODE[0]));
        chk("zero_nb_d0", 32'(disp[0]), 32'(CODE[0]));

        // Anode dwell time and one-hot property
        a = anode_a;
        n = 0;
        while (anode_a == a && n < 50) begin
            @(negedge clk);
            n++;
        end
        a = anode_a;
        run = 0;
        while (anode_a == a && run < 50) begin
            run++;
            @(negedge clk);
        end
        chk("anode_dwell", 32'(run), 32'd4);
        bad_onehot = 0;
        repeat (32) begin
            if ($countones(~anode_a) != 1) bad_onehot++;
            @(negedge clk);
        end
        chk("anode_onehot", 32'(bad_onehot), 32'd0);

        // 1234: ready low for DATA_W+1 cycles
        load(0, 14'd1234);
        chk("conv_busy", 32'(busy_a), 32'd1);
        wait_ready(0, n);
        chk("ready_low_cycles", 32'(n), 32'd14);
        read_disp(0);
        chk("v1234_d3", 32'(disp[3]), 32'(CODE[1]));
        chk("v1234_d2", 32'(disp[2]), 32'(CODE[2]));
        chk("v1234_d1", 32'(disp[1]), 32'(CODE[3]));
        chk("v1234_d0", 32'(disp[0]), 32'(CODE[4]));

        show("v7_lz", 0, 14'd7, BLANK, BLANK, BLANK, CODE[7]);
        show("v7_nb", 1, 14'd7, CODE[0], CODE[0], CODE[0], CODE[7]);
        show("v1020", 0, 14'd1020, CODE[1], CODE[0], CODE[2], CODE[0]);

`ifndef SSEG_SIGNED_EN
        show("v8191", 0, 14'd8191, CODE[8], CODE[1], CODE[9], CODE[1]);
        show("v10000", 1, 14'd10000, DASH, DASH, DASH, DASH);
        show("v9999", 1, 14'd9999, CODE[9], CODE[9], CODE[9], CODE[9]);
`endif

        // in_valid held across a conversion: second value waits for in_ready
        @(negedge clk);
        in_valid_a = 1'b1;
        in_data_a  = 13'd5;
        n = 0;
        while (!in_ready_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_wait_timeout", 32'(n >= 100), 32'd0);
        @(negedge clk);
        in_data_a = 13'd6;
        run = 1;
        while (!in_ready_a && run < 100) begin
            @(negedge clk);
            run++;
        end
        chk("accept_gap", 32'(run), 32'd15);
        @(negedge clk);
        in_valid_a = 1'b0;
        chk("hold_busy", 32'(busy_a), 32'd1);
        wait_ready(0, n);
        read_disp(0);
        chk("v6_d1", 32'(disp[1]), 32'(BLANK));
        chk("v6_d0", 32'(disp[0]), 32'(CODE[6]));

        // Reset during a conversion
        load(0, 14'd4321);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_anode", 32'(anode_a), 32'h0F);
        chk("midrst_seg", 32'(seg_a), 32'h7F);
        chk("midrst_ready", 32'(in_ready_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", 32'(in_ready_a), 32'd1);
        read_disp(0);
        chk("midrst_d3", 32'(disp[3]), 32'(BLANK));
        chk("midrst_d1", 32'(disp[1]), 32'(BLANK));
        chk("midrst_d0", 32'(disp[0]), 32'(CODE[0]));

`ifdef SSEG_SIGNED_EN
        show("neg42", 0, 14'h1FD6, BLANK, DASH, CODE[4], CODE[2]);
        show("neg1000", 0, 14'h1C18, DASH, DASH, DASH, DASH);
        show("neg7_nb", 1, 14'h3FF9, DASH, CODE[0], CODE[0], CODE[7]);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
